// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit scheduler.
package spi_pkg;

  localparam int SPI_WORD_BITS = 16;
  localparam int NUM_REQ       = 4;
  localparam int REQ_ID_W      = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    SHIFT,
    HOLD
  } spi_state_e;

  // One-hot strobe for a requester index.
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [REQ_ID_W-1:0] id);
    logic [NUM_REQ-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick over four requesters. The search starts one
// past the last winner (ptr) and wraps.
module rr_arbiter4
  import spi_pkg::*;
(
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic                valid,
  output logic [REQ_ID_W-1:0] winner
);

  assign valid = |req;

  // Scan from farthest to nearest so the nearest active requester is assigned last and wins.
  always_comb begin
    winner = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[REQ_ID_W'(ptr + REQ_ID_W'(k))]) begin
        winner = REQ_ID_W'(ptr + REQ_ID_W'(k));
      end
    end
  end

endmodule

// File: rtl/spi_tx_scheduler.sv
// Arbitrates four word requesters and frames each captured word for the SPI
// transmitter: generates cs_n, sclk (16 cycles, idle low) and a load strobe,
// then holds cs_n high for a fixed gap before the next word.
module spi_tx_scheduler
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int GAP_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*SPI_WORD_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]               ack,
  output logic [NUM_REQ-1:0]               done,
  output logic                             busy,
  output logic [REQ_ID_W-1:0]              grant_id,
  output logic                             sclk,
  output logic                             cs_n,
  output logic                             tx_req,
  output logic [SPI_WORD_BITS-1:0]         tx_data
);

  localparam logic [7:0]       DIV_TC  = 8'(CLK_DIV - 1);
  localparam logic [4:0]       EDGE_TC = 5'(SPI_WORD_BITS - 1);
  localparam int               GAP_W   = $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_TC  = GAP_W'(GAP_CYCLES - 1);

  spi_state_e          state, state_d;
  logic [7:0]          div_cnt;
  logic [4:0]          edge_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [REQ_ID_W-1:0] rr_ptr;
  logic                arb_valid;
  logic [REQ_ID_W-1:0] arb_winner;
  logic                div_tc;
  logic                last_fall;
  logic                gap_tc;

  rr_arbiter4 u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // Half-period terminal count; a toggle while sclk is high is a falling edge.
  assign div_tc    = (state == SHIFT) && (div_cnt == DIV_TC);
  assign last_fall = div_tc && sclk && (edge_cnt == EDGE_TC);
  assign gap_tc    = (state == HOLD) && (gap_cnt == GAP_TC);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    case (state)
      IDLE:    if (arb_valid) state_d = GRANT;
      GRANT:   state_d = SHIFT;
      SHIFT:   if (last_fall) state_d = HOLD;
      HOLD:    if (gap_tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on grant, sclk/edge counting in SHIFT, gap timing in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack      <= '0;
      done     <= '0;
      tx_req   <= 1'b0;
      grant_id <= '0;
      tx_data  <= '0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      div_cnt  <= '0;
      edge_cnt <= '0;
      gap_cnt  <= '0;
      rr_ptr   <= REQ_ID_W'(NUM_REQ - 1);
    end else begin
      ack    <= '0;
      done   <= '0;
      tx_req <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_id <= arb_winner;
            rr_ptr   <= arb_winner;
            tx_data  <= req_data[arb_winner*SPI_WORD_BITS +: SPI_WORD_BITS];
            ack      <= req_onehot(arb_winner);
            tx_req   <= 1'b1;
            cs_n     <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sclk) begin
              if (edge_cnt == EDGE_TC) begin
                // Sixteenth falling edge: close the frame and start the gap.
                edge_cnt       <= '0;
                cs_n           <= 1'b1;
                done[grant_id] <= 1'b1;
                gap_cnt        <= '0;
              end else begin
                edge_cnt <= edge_cnt + 5'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (!gap_tc) gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Self-checking bench for spi_tx_scheduler (CLK_DIV=2, GAP_CYCLES=4).
`timescale 1ns/1ps
module tb_spi_tx_scheduler;
  import spi_pkg::*;

  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 4;
  localparam int PERIOD     = 2 + 32*CLK_DIV + GAP_CYCLES;  // 70
  localparam int ACK2DONE   = 1 + 32*CLK_DIV;               // GRANT + SHIFT = 65

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  ack, done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        sclk, cs_n, tx_req;
  logic [15:0] tx_data;

  spi_tx_scheduler #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .done(done), .busy(busy), .grant_id(grant_id),
    .sclk(sclk), .cs_n(cs_n), .tx_req(tx_req), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor: cycle count, sclk edges, invariants, transmitter model
  int          cyc = 0, falls = 0, win_falls = 0, inv_bad = 0, rx_n = 0;
  logic        sclk_q = 1'b0, cs_n_q = 1'b1;
  logic [15:0] xsr = '0, rx = '0;

  always @(negedge clk) begin
    cyc++;
    if (sclk_q && !sclk) begin falls++; win_falls++; end
    if (tx_req && dut.state != GRANT) begin
      inv_bad++; $display("FAIL inv_tx_req: tx_req=1 in state %0d, expected GRANT", dut.state);
    end
    if (!cs_n && !busy) begin
      inv_bad++; $display("FAIL inv_cs_busy: cs_n=0 with busy=0, expected busy=1");
    end
    if (!$onehot0(ack) || !$onehot0(done)) begin
      inv_bad++; $display("FAIL inv_onehot: ack=%b done=%b, expected one-hot or zero", ack, done);
    end
    if (!rst) win_falls = 0;
    else if (cs_n && !cs_n_q) begin
      if (win_falls != 16) begin
        inv_bad++; $display("FAIL inv_edges: %0d falling edges in cs_n window, expected 16", win_falls);
      end
      win_falls = 0;
    end
    // Transmitter: load on tx_req, present MSB, shift on sclk fall; receiver samples on rise.
    if (tx_req) begin xsr = tx_data; rx_n = 0; end
    else if (sclk_q && !sclk) xsr = {xsr[14:0], 1'b0};
    if (!sclk_q && sclk) begin rx = {rx[14:0], xsr[15]}; rx_n++; end
    sclk_q = sclk;
    cs_n_q = cs_n;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return ack != '0;
      1:       return done != '0;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int limit, output int waited);
    waited = 0;
    while (!cond(which) && waited < limit) begin step(); waited++; end
    if (!cond(which)) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no event after %0d cycles, expected event", name, limit);
    end
  endtask

  // Reference arbitration: first active requester at last+1, last+2, ... (mod 4).
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int s = 1; s <= NUM_REQ; s++)
      if (r[(last + s) % NUM_REQ]) return (last + s) % NUM_REQ;
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  req;
    int          exp_id;
    logic [15:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int w, f0, c0, prev_c, d;
    // ---------------- reset state
    #1 rst = 1'b0;
    step();
    check("rst_sclk", sclk, 0);      check("rst_cs_n", cs_n, 1);
    check("rst_tx_req", tx_req, 0);  check("rst_ack", ack, 0);
    check("rst_done", done, 0);      check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0); check("rst_tx_data", tx_data, 0);
    check("rst_ptr", dut.rr_ptr, 3); check("rst_div", dut.div_cnt, 0);
    check("rst_edge", dut.edge_cnt, 0);
    repeat (2) step();
    rst = 1'b1;
    step();

    // ---------------- single request
    req_data[15:0] = 16'hA5C3;
    req = 4'b0001;
    step();
    check("single_ack", ack, 4'b0001);
    check("single_tx_req", tx_req, 1);
    check("single_tx_data", tx_data, 16'hA5C3);
    check("single_cs_n", cs_n, 0);
    req = '0;
    f0 = falls;
    wait_for("single_done", 1, 200, w);
    check("single_done_lat", w, ACK2DONE);
    check("single_done_vec", done, 4'b0001);
    check("single_falls", falls - f0, 16);
    check("single_cs_n_hi", cs_n, 1);
    wait_for("single_idle", 2, 50, w);
    check("single_busy_lat", w, GAP_CYCLES);

    // ---------------- end-to-end shift order
    req_data[31:16] = 16'hBEEF;
    req = 4'b0010;
    step();
    check("e2e_ack", ack, 4'b0010);
    req = '0;
    wait_for("e2e_done", 1, 200, w);
    check("e2e_bits", rx, 16'hBEEF);
    check("e2e_nbits", rx_n, 16);
    wait_for("e2e_idle", 2, 50, w);

    // ---------------- table-driven arbitration from reset
    do_reset();
    req_data = {16'h4D04, 16'h3C03, 16'h2B02, 16'h1A01};
    vecs[0] = '{4'b0001, 0, 16'h1A01};
    vecs[1] = '{4'b0011, 1, 16'h2B02};
    vecs[2] = '{4'b0011, 0, 16'h1A01};
    vecs[3] = '{4'b1100, 2, 16'h3C03};
    vecs[4] = '{4'b1101, 3, 16'h4D04};
    vecs[5] = '{4'b0110, 1, 16'h2B02};
    vecs[6] = '{4'b1000, 3, 16'h4D04};
    vecs[7] = '{4'b1111, 0, 16'h1A01};
    for (int i = 0; i < 8; i++) begin
      wait_for("tbl_idle", 2, 100, w);
      req = vecs[i].req;
      step();
      check($sformatf("tbl%0d_ack", i), ack, 64'(req_onehot(2'(vecs[i].exp_id))));
      check($sformatf("tbl%0d_id", i), grant_id, 64'(vecs[i].exp_id));
      check($sformatf("tbl%0d_data", i), tx_data, vecs[i].exp_word);
      req = '0;
      wait_for("tbl_done", 1, 200, w);
      check($sformatf("tbl%0d_done", i), done, 64'(req_onehot(2'(vecs[i].exp_id))));
    end
    wait_for("tbl_idle_end", 2, 100, w);

    // ---------------- fairness, all requests held
    do_reset();
    req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    step();
    req = 4'b1111;
    prev_c = 0;
    for (int n = 0; n < 5; n++) begin
      wait_for("fair_ack", 0, 200, w);
      check($sformatf("fair%0d_id", n), grant_id, 64'(n % 4));
      check($sformatf("fair%0d_data", n), tx_data, {4{4'(n % 4 + 1)}});
      if (n > 0) check($sformatf("fair%0d_period", n), cyc - prev_c, PERIOD);
      prev_c = cyc;
      step();
    end
    req = '0;
    wait_for("fair_idle", 2, 200, w);

    // ---------------- late arrival during SHIFT
    do_reset();
    step();
    req = 4'b0001;
    step();
    check("late_ack0", ack, 4'b0001);
    c0 = cyc;
    req = '0;
    repeat (20) step();
    req = 4'b0100;
    wait_for("late_ack2", 0, 200, w);
    check("late_id", grant_id, 2);
    check("late_period", cyc - c0, PERIOD);
    req = '0;
    wait_for("late_idle", 2, 200, w);

    // ---------------- reset abort after 5 falling edges
    req = 4'b0001;
    step();
    check("abort_ack", ack, 4'b0001);
    req = '0;
    f0 = falls;
    w = 0;
    while (!((falls - f0) >= 5 && sclk) && w < 200) begin step(); w++; end
    check("abort_pre_sclk", sclk, 1);
    rst = 1'b0;
    #1;
    check("abort_sclk", sclk, 0);
    check("abort_cs_n", cs_n, 1);
    check("abort_busy", busy, 0);
    check("abort_ptr", dut.rr_ptr, 3);
    repeat (2) step();
    rst = 1'b1;
    d = 0;
    for (int i = 0; i < 80; i++) begin step(); if (done != '0) d++; end
    check("abort_no_done", d, 0);
    req = 4'b1000;
    wait_for("abort_ack3", 0, 10, w);
    check("abort_id", grant_id, 3);
    req = '0;
    wait_for("abort_idle", 2, 200, w);

    // ---------------- randomized traffic against a cycle-level reference
    begin
      logic [3:0]  r;
      logic [15:0] words[4];
      int          free_k, last, m_ack_k, m_done_k, m_win, m_dwin, win;
      logic [15:0] m_word;
      do_reset();
      r = '0; free_k = 0; last = 3; m_ack_k = -1; m_done_k = -1; m_win = 0; m_dwin = 0; m_word = '0;
      for (int i = 0; i < 4; i++) words[i] = '0;
      for (int k = 0; k < 3000; k++) begin
        step();
        check("rnd_busy", busy, 64'(k < free_k));
        if (ack != '0 || k == m_ack_k) begin
          check("rnd_ack", ack, (k == m_ack_k) ? 64'(req_onehot(2'(m_win))) : 64'd0);
          if (k == m_ack_k) check("rnd_data", tx_data, m_word);
        end
        if (done != '0 || k == m_done_k)
          check("rnd_done", done, (k == m_done_k) ? 64'(req_onehot(2'(m_dwin))) : 64'd0);
        for (int i = 0; i < 4; i++) begin
          if (ack[i]) r[i] = 1'b0;
          else if (r[i] && $urandom_range(0, 199) == 0) r[i] = 1'b0;
          else if (!r[i] && $urandom_range(0, 39) == 0) begin
            r[i] = 1'b1;
            words[i] = 16'($urandom);
          end
        end
        if (k >= free_k && r != '0) begin
          win = rr_pick(r, last);
          m_win = win; m_dwin = win; m_word = words[win];
          m_ack_k = k + 1; m_done_k = k + 1 + ACK2DONE;
          free_k = k + PERIOD;
          last = win;
        end
        req = r;
        req_data = {words[3], words[2], words[1], words[0]};
      end
      req = '0;
    end

    check("invariants", inv_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
